line_burst_adaptor: RTL

Memory-side responder for the cache datapath's line interface. Accepts full-line read (fill) and write (writeback) requests from the cache controller/datapath and converts each into a 4-beat, 64-bit burst on the physical memory bus. On a read, it reassembles the line from the beats. Sits between the cache and the memory model/arbiter.

---
 rtl/line_adaptor_pkg.sv | 14 +
 rtl/line_burst_adaptor.sv | 121 ++++++++++++
 2 files changed

// File: rtl/line_adaptor_pkg.sv
// Shared types and defaults for the cache line <-> memory burst adaptor.
package line_adaptor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int NUM_BEATS_DEFAULT = 4;
  localparam int S_BEAT_DEFAULT    = 64;

endpackage

// File: rtl/line_burst_adaptor.sv
// Converts full-line fill/writeback requests into NUM_BEATS-beat bursts on the memory bus.
// Optional LINE_ADAPTOR_ALIGN_EN forces the burst address to be line-aligned.
module line_burst_adaptor
  import line_adaptor_pkg::*;
#(
  parameter int S_OFFSET  = 5,
  parameter int S_LINE    = 8 * 2**S_OFFSET,
  parameter int S_BEAT    = S_BEAT_DEFAULT,
  parameter int NUM_BEATS = S_LINE / S_BEAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [S_LINE-1:0] line_i,
  output logic [S_LINE-1:0] line_o,
  input  logic [31:0]       address_i,
  input  logic              read_i,
  input  logic              write_i,
  output logic              resp_o,
  input  logic [S_BEAT-1:0] burst_i,
  output logic [S_BEAT-1:0] burst_o,
  output logic [31:0]       address_o,
  output logic              read_o,
  output logic              write_o,
  input  logic              resp_i
);

  localparam int              CW        = $clog2(NUM_BEATS);
  localparam logic [CW-1:0]   LAST_BEAT = CW'(NUM_BEATS - 1);

  state_t            state_q, state_d;
  logic [CW-1:0]     beat_q;
  logic [31:0]       addr_q;
  logic [S_LINE-1:0] line_q;
  logic [S_LINE-1:0] wbuf_q;

  logic start;
  assign start = (state_q == IDLE) && (read_i || write_i);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (write_i)     state_d = WRITE;  // writeback precedes fill
        else if (read_i) state_d = READ;
      end
      READ, WRITE: begin
        if (resp_i && (beat_q == LAST_BEAT)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    read_o  = 1'b0;
    write_o = 1'b0;
    resp_o  = 1'b0;
    burst_o = '0;
    case (state_q)
      READ:  read_o = 1'b1;
      WRITE: begin
        write_o = 1'b1;
        burst_o = wbuf_q[beat_q*S_BEAT +: S_BEAT];
      end
      DONE:    resp_o = 1'b1;
      default: ;
    endcase
  end

  // Address, beat counter and assembled line; the counter wraps naturally after the last beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      beat_q <= '0;
      line_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            addr_q <= address_i;
            beat_q <= '0;
          end
        end
        READ: begin
          if (resp_i) begin
            line_q[beat_q*S_BEAT +: S_BEAT] <= burst_i;
            beat_q                          <= beat_q + 1'b1;
          end
        end
        WRITE: begin
          if (resp_i) beat_q <= beat_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: the write buffer is pure data storage with no reset; it is only
  // observed on burst_o while in WRITE, after it has been loaded.
  always_ff @(posedge clk) begin
    if ((state_q == IDLE) && write_i) wbuf_q <= line_i;
  end

  assign line_o = line_q;

`ifdef LINE_ADAPTOR_ALIGN_EN
  assign address_o = {addr_q[31:S_OFFSET], {S_OFFSET{1'b0}}};
`else
  assign address_o = addr_q;
`endif

endmodule
